// File: rtl/alu_pkg.sv
// alu_pkg: alu16 opcodes and multiply sequencer state encoding
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu16_mul_seq_if.sv
// alu16_mul_seq_if: start/abort/busy/done handshake and operand/product bus of the multiplier
interface alu16_mul_seq_if;
  logic start;
  logic abort;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic busy;
  logic done;
  logic [31:0] product;
  modport master (output start, abort, mcand, mplier, input busy, done, product);
  modport slave (input start, abort, mcand, mplier, output busy, done, product);
endinterface

// File: rtl/alu16.sv
// alu16: 16-bit ALU with carry/borrow out on add, subtract and 1-bit shifts
module alu16 import alu_pkg::*; (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [2:0]  op_i,
  input  logic        cin_i,
  output logic [15:0] s_o,
  output logic        c_o
);
  logic [16:0] r;
  always_comb r = op_i == OP_SUB ? {1'b0, a_i} - {1'b0, b_i} - 17'(cin_i) :
                  op_i == OP_SHL ? {a_i, 1'b0} :
                  op_i == OP_SHR ? {a_i[0], 1'b0, a_i[15:1]} :
                  {1'b0, a_i} + {1'b0, b_i} + 17'(cin_i);
  assign {c_o, s_o} = r;
endmodule

// File: rtl/alu16_mul_seq.sv
// alu16_mul_seq: unsigned 16x16->32 shift-and-add multiplier sequencing one alu16
module alu16_mul_seq #(
  parameter logic [2:0] OP_ADD     = alu_pkg::OP_ADD,
  parameter bit         EARLY_EXIT = 1'b0
) (
  input logic clk,
  input logic rst,
  alu16_mul_seq_if.slave bus
);
  import alu_pkg::state_t, alu_pkg::IDLE, alu_pkg::RUN, alu_pkg::DONE;
  state_t st_q, st_d;
  logic [15:0] m_q, m_d, ph_q, ph_d, pl_q, pl_d, a, b, s, rest;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d, fin;
  logic [32:0] acc;
  logic        c, run, last;
  assign run = st_q == RUN;
  assign a = run ? ph_q : 16'h0000;
  assign b = run && pl_q[0] ? m_q : 16'h0000;
  alu16 u_alu (.a_i(a), .b_i(b), .op_i(OP_ADD), .cin_i(1'b0), .s_o(s), .c_o(c));
  assign acc = {c, s, pl_q};
  // multiplier bits not yet consumed after this step; zero means the rest are pure shifts
  assign rest = (pl_q >> 1) & ((16'h0001 << (5'd15 - cnt_q)) - 16'h0001);
  assign last = cnt_q == 5'd15 || (EARLY_EXIT && rest == 16'h0000);
  assign fin = 32'(acc >> (5'd16 - cnt_q));
  always_comb begin
    st_d = st_q;
    m_d = m_q;
    ph_d = ph_q;
    pl_d = pl_q;
    cnt_d = cnt_q;
    prod_d = prod_q;
    if (st_q == IDLE && bus.start && !bus.abort) begin
      st_d = RUN;
      m_d = bus.mcand;
      ph_d = 16'h0000;
      pl_d = bus.mplier;
      cnt_d = 5'd0;
    end else if (bus.abort) begin
      st_d = IDLE;
    end else if (run) begin
      {ph_d, pl_d} = last ? fin : acc[32:1];
      cnt_d = cnt_q + 5'd1;
      st_d = last ? DONE : RUN;
      prod_d = last ? fin : prod_q;
    end else if (st_q == DONE) begin
      st_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= IDLE;
      m_q <= '0;
      ph_q <= '0;
      pl_q <= '0;
      cnt_q <= '0;
      prod_q <= '0;
    end else begin
      st_q <= st_d;
      m_q <= m_d;
      ph_q <= ph_d;
      pl_q <= pl_d;
      cnt_q <= cnt_d;
      prod_q <= prod_d;
    end
  end
  assign bus.busy = st_q != IDLE;
  assign bus.done = st_q == DONE;
  assign bus.product = prod_q;
endmodule
